// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator for a word-only data memory.
// Optional per-kind request counters are enabled by defining MEM_ACCESS_STATS_EN.
module mem_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misaligned,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
`ifdef MEM_ACCESS_STATS_EN
   ,
   output logic [31:0] stat_loads,
   output logic [31:0] stat_stores,
   output logic [31:0] stat_rmw,
   output logic [31:0] stat_faults
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD_RESP, RMW_WRITE} state_t;

   state_t      state, next_state;
   logic [31:0] rbuf;
   logic [1:0]  r_size, r_off;
   logic        r_signed;
   logic        is_byte, is_half, fault, capture;
   logic [31:0] shifted, merged, extended;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      is_byte = (req_size == 2'b00);
      is_half = (req_size == 2'b01);
      fault   = (is_half & req_addr[0]) | (~is_byte & ~is_half & (|req_addr[1:0]));
      mem_a   = {req_addr[31:2], 2'b00};
   end

   // Response data comes only from the captured word and captured request fields.
   always_comb begin
      shifted = rbuf >> {r_off, 3'b000};
      lane_b  = shifted[7:0];
      lane_h  = r_off[1] ? rbuf[31:16] : rbuf[15:0];
      case (r_size)
         2'b00:   extended = {{24{r_signed & lane_b[7]}}, lane_b};
         2'b01:   extended = {{16{r_signed & lane_h[15]}}, lane_h};
         default: extended = rbuf;
      endcase
      merged = rbuf;
      if (r_size == 2'b00)
         merged[{r_off, 3'b000} +: 8] = req_wdata[7:0];
      else
         merged[{r_off[1], 4'b0000} +: 16] = req_wdata[15:0];
   end

   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'd0;
      misaligned = 1'b0;
      mem_we     = 1'b0;
      mem_wd     = 32'd0;
      capture    = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (fault) begin
                     req_ready  = 1'b1;
                     misaligned = 1'b1;
                  end else if (req_we && !is_byte && !is_half) begin
                     mem_we    = 1'b1;
                     mem_wd    = req_wdata;
                     req_ready = 1'b1;
                  end else begin
                     capture    = 1'b1;
                     next_state = req_we ? RMW_WRITE : LOAD_RESP;
                  end
               end
            end
            LOAD_RESP: begin
               req_ready  = 1'b1;
               resp_valid = 1'b1;
               resp_rdata = extended;
               next_state = IDLE;
            end
            RMW_WRITE: begin
               mem_we     = 1'b1;
               mem_wd     = merged;
               req_ready  = 1'b1;
               next_state = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
      stall = req_valid & ~req_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rbuf     <= 32'd0;
         r_size   <= 2'b00;
         r_off    <= 2'b00;
         r_signed <= 1'b0;
      end else begin
         state <= next_state;
         if (capture) begin
            rbuf     <= mem_rd;
            r_size   <= req_size;
            r_off    <= req_addr[1:0];
            r_signed <= req_signed;
         end
      end
   end

`ifdef MEM_ACCESS_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_loads  <= 32'd0;
         stat_stores <= 32'd0;
         stat_rmw    <= 32'd0;
         stat_faults <= 32'd0;
      end else begin
         if (resp_valid)           stat_loads  <= stat_loads + 32'd1;
         if (mem_we && req_ready)  stat_stores <= stat_stores + 32'd1;
         if (state == RMW_WRITE)   stat_rmw    <= stat_rmw + 32'd1;
         if (misaligned)           stat_faults <= stat_faults + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a word-only memory.
// Set MEM_ACCESS_STATS_EN to also check the request counters.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b10;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        req_ready, stall, resp_valid, misaligned, mem_we;
   logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;
`ifdef MEM_ACCESS_STATS_EN
   logic [31:0] stat_loads, stat_stores, stat_rmw, stat_faults;
   int          bl = 0, bs = 0, br = 0, bf = 0;
`endif

   logic [31:0] mem [0:63];
   logic [31:0] ref_mem [0:63];

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int          lat;
      logic        mis;
      logic        rv;
      logic [31:0] rdata;
      logic        we;
      logic [31:0] wd;
   } exp_t;
   exp_t sb[$];

   mem_access_unit dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .stall(stall),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misaligned(misaligned),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef MEM_ACCESS_STATS_EN
      , .stat_loads(stat_loads), .stat_stores(stat_stores),
      .stat_rmw(stat_rmw), .stat_faults(stat_faults)
`endif
   );

   always #5 clk = ~clk;

   assign mem_rd = mem[mem_a[7:2]];
   always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*off +: 8];
      h = w[16*off[1] +: 16];
      if (size == 2'b00) return (sgn && b[7]) ? (32'hFFFFFF00 | 32'(b)) : 32'(b);
      if (size == 2'b01) return (sgn && h[15]) ? (32'hFFFF0000 | 32'(h)) : 32'(h);
      return w;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] off, input logic [31:0] d);
      logic [31:0] r;
      r = w;
      if (size == 2'b00) r[8*off +: 8] = d[7:0];
      else if (size == 2'b01) r[16*off[1] +: 16] = d[15:0];
      else r = d;
      return r;
   endfunction

   task automatic issue(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e, o;
      logic mis;
      int   idx, cyc;
      bit   done;
      idx = int'(addr[7:2]);
      mis = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
      e.mis = mis; e.rv = 0; e.rdata = 0; e.we = 0; e.wd = 0; e.lat = 0;
      if (mis) begin
`ifdef MEM_ACCESS_STATS_EN
         bf++;
`endif
      end else if (!we) begin
         e.lat = 1; e.rv = 1;
         e.rdata = model_load(ref_mem[idx], size, sgn, addr[1:0]);
`ifdef MEM_ACCESS_STATS_EN
         bl++;
`endif
      end else begin
         e.we = 1;
         e.lat = size[1] ? 0 : 1;
         e.wd = model_store(ref_mem[idx], size, addr[1:0], wdata);
         ref_mem[idx] = e.wd;
`ifdef MEM_ACCESS_STATS_EN
         bs++;
         if (!size[1]) br++;
`endif
      end
      sb.push_back(e);
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      cyc = 0;
      done = 0;
      while (!done && cyc < 8) begin
         @(negedge clk);
         if (cyc == 0) check_eq({tag, " mem_a"}, mem_a, {addr[31:2], 2'b00});
         if (req_ready) begin
            o = sb.pop_front();
            check_eq({tag, " latency"}, 32'(cyc), 32'(o.lat));
            check_eq({tag, " misaligned"}, {31'd0, misaligned}, {31'd0, o.mis});
            check_eq({tag, " resp_valid"}, {31'd0, resp_valid}, {31'd0, o.rv});
            check_eq({tag, " resp_rdata"}, resp_rdata, o.rdata);
            check_eq({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, o.we});
            if (o.we) check_eq({tag, " mem_wd"}, mem_wd, o.wd);
            check_eq({tag, " stall_done"}, {31'd0, stall}, 32'd0);
            done = 1;
         end else begin
            check_eq({tag, " stall"}, {31'd0, stall}, 32'd1);
            check_eq({tag, " early_we"}, {31'd0, mem_we}, 32'd0);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s timeout: req_ready not seen in %0d cycles, required within 2", tag, cyc);
         void'(sb.pop_front());
      end
      if (we && !mis) check_eq({tag, " mem_commit"}, mem[idx], ref_mem[idx]);
      req_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h12345678;
      repeat (2) begin
         @(negedge clk);
         check_eq("rst req_ready", {31'd0, req_ready}, 32'd0);
         check_eq("rst resp_valid", {31'd0, resp_valid}, 32'd0);
         check_eq("rst resp_rdata", resp_rdata, 32'd0);
         check_eq("rst misaligned", {31'd0, misaligned}, 32'd0);
         check_eq("rst mem_we", {31'd0, mem_we}, 32'd0);
         check_eq("rst mem_wd", mem_wd, 32'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      req_valid = 1'b0;

      issue("ws10",   1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
      issue("lw10",   0, 2'b10, 0, 32'h10, 32'h0);
      issue("ws20",   1, 2'b10, 0, 32'h20, 32'h11223344);
      issue("lbs23",  0, 2'b00, 1, 32'h23, 32'h0);
      issue("sb21",   1, 2'b00, 0, 32'h21, 32'hFFFFFFAA);
      issue("lw20",   0, 2'b10, 0, 32'h20, 32'h0);
      issue("ws20b",  1, 2'b10, 0, 32'h20, 32'h80FF0000);
      issue("lhs22",  0, 2'b01, 1, 32'h22, 32'h0);
      issue("lhu22",  0, 2'b01, 0, 32'h22, 32'h0);
      issue("lbs22",  0, 2'b00, 1, 32'h22, 32'h0);
      issue("sh20",   1, 2'b01, 0, 32'h20, 32'h1234BEEF);
      issue("lbu21",  0, 2'b00, 0, 32'h21, 32'h0);
      issue("sb23",   1, 2'b00, 0, 32'h23, 32'h00000077);
      issue("sh22",   1, 2'b01, 0, 32'h22, 32'h0000A5A5);
      issue("lw20c",  0, 2'b10, 0, 32'h20, 32'h0);
      issue("shmis",  1, 2'b01, 0, 32'h21, 32'h0000FFFF);
      issue("lwmis",  0, 2'b10, 0, 32'h22, 32'h0);
      issue("sz3mis", 1, 2'b11, 0, 32'h11, 32'h0);
      issue("sz3lw",  0, 2'b11, 1, 32'h10, 32'h0);
      issue("lhs20",  0, 2'b01, 1, 32'h20, 32'h0);

`ifdef MEM_ACCESS_STATS_EN
      @(negedge clk);
      check_eq("stat_loads", stat_loads, 32'(bl));
      check_eq("stat_stores", stat_stores, 32'(bs));
      check_eq("stat_rmw", stat_rmw, 32'(br));
      check_eq("stat_faults", stat_faults, 32'(bf));
      @(posedge clk);
      #1;
`endif

      issue("ws28", 1, 2'b10, 0, 32'h28, 32'hCAFEF00D);
      req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h29; req_wdata = 32'h55;
      req_valid = 1'b1;
      @(negedge clk);
      check_eq("rmwrst stall", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check_eq("rmwrst mem_we", {31'd0, mem_we}, 32'd0);
      check_eq("rmwrst req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      req_valid = 1'b0;
      check_eq("rmwrst mem", mem[10], 32'hCAFEF00D);
`ifdef MEM_ACCESS_STATS_EN
      bl = 0; bs = 0; br = 0; bf = 0;
`endif
      issue("lw28",   0, 2'b10, 0, 32'h28, 32'h0);
      issue("lb29",   0, 2'b00, 1, 32'h29, 32'h0);
      issue("sb28",   1, 2'b00, 0, 32'h28, 32'h000000AA);
      issue("lw28b",  0, 2'b10, 0, 32'h28, 32'h0);
      issue("ws2c",   1, 2'b10, 0, 32'h2C, 32'h01020304);
      issue("lbmis",  0, 2'b01, 0, 32'h2F, 32'h0);

`ifdef MEM_ACCESS_STATS_EN
      @(negedge clk);
      check_eq("stat2_loads", stat_loads, 32'(bl));
      check_eq("stat2_stores", stat_stores, 32'(bs));
      check_eq("stat2_rmw", stat_rmw, 32'(br));
      check_eq("stat2_faults", stat_faults, 32'(bf));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
